// File: rtl/colparity_stage_pkg.sv
// -----------------------------------------------------------------------------
// colparity_stage_pkg
//
// Purpose:
//   Shared definitions for the column-parity mixing stage of the matrix
//   encoder. The definitions are:
//   - the line geometry constants.
//   - the stage FSM state type.
//   - a helper that folds a 5x5 slice down to its five column parities.
//
// Contents:
//   LINE_W       bits per line (one 5x5 slice)
//   DIM          side length of a slice
//   FRAME_LINES  lines per frame
//   state_t      LOAD (accepting a frame) / EMIT (draining mixed lines)
//   col_parity   C[x] = XOR over y of line[5*y + x]
// -----------------------------------------------------------------------------
package colparity_stage_pkg;

  localparam int LINE_W      = 25;
  localparam int DIM         = 5;
  localparam int FRAME_LINES = 64;

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Column parity of one slice: bit x is the XOR of the five bits that share
  // column x, one from each row y.
  function automatic logic [DIM-1:0] col_parity(input logic [LINE_W-1:0] line);
    logic [DIM-1:0] par;
    par = '0;
    for (int y = 0; y < DIM; y++) begin
      for (int x = 0; x < DIM; x++) begin
        par[x] = par[x] ^ line[DIM*y + x];
      end
    end
    return par;
  endfunction

endpackage

// File: rtl/colparity_stage_theta_mix.sv
// -----------------------------------------------------------------------------
// theta_mix
//
// Purpose:
//   Purely combinational column-parity mix of one slice. Every bit of the
//   slice is XORed with two column parities:
//   - the parity of the neighbouring column to its left, taken from the
//     same slice.
//   - the parity of the neighbouring column to its right, taken from the
//     previous slice.
//
// Ports:
//   line      in   LINE_W  slice z
//   par_cur   in   DIM     column parities C[.][z]
//   par_prev  in   DIM     column parities C[.][z-1] (wrapped by the caller)
//   mixed     out  LINE_W  mixed slice:
//                          mixed[5y+x] = line[5y+x] ^ C[(x+4)%5][z] ^ C[(x+1)%5][z-1]
// -----------------------------------------------------------------------------
module theta_mix
  import colparity_stage_pkg::*;
(
  input  logic [LINE_W-1:0] line,
  input  logic [DIM-1:0]    par_cur,
  input  logic [DIM-1:0]    par_prev,
  output logic [LINE_W-1:0] mixed
);

  // NOTE: every signal written in an always_comb gets a default before any
  // conditional or loop assignment, so no path can leave it unassigned and
  // infer a latch.
  always_comb begin
    mixed = '0;
    for (int y = 0; y < DIM; y++) begin
      for (int x = 0; x < DIM; x++) begin
        // (x + DIM - 1) % DIM is x-1 with wrap, kept non-negative.
        mixed[DIM*y + x] = line[DIM*y + x]
                         ^ par_cur[(x + DIM - 1) % DIM]
                         ^ par_prev[(x + 1) % DIM];
      end
    end
  end

endmodule

// File: rtl/colparity_stage.sv
// -----------------------------------------------------------------------------
// colparity_stage
//
// Purpose:
//   This is the frame-based column-parity mixing stage. The stage runs in
//   two phases:
//   - LOAD: it accepts LINES slices and stores each line in a buffer. The
//     line's column parity is stored next to it.
//   - EMIT: it emits LINES mixed slices in order.
//   Slice 0's output needs the parity of the last slice, so a whole frame
//   must be resident before the first output can be produced.
//
// Parameters:
//   LINES  lines per frame (power of two >= 2)
//   W      line width (fixed at 25, one 5x5 slice)
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active high
//   in_valid   in   1      upstream presents in_line
//   in_ready   out  1      stage accepts in_line (high throughout LOAD)
//   in_line    in   W      input slice
//   out_valid  out  1      out_line / out_index valid (high throughout EMIT)
//   out_ready  in   1      downstream accepts the output
//   out_line   out  W      mixed slice (0 while not emitting)
//   out_index  out  log2   slice number z of out_line
//   done       out  1      one-cycle pulse after the last output transfer
//
// All outputs decode registered state only; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module colparity_stage
  import colparity_stage_pkg::*;
#(
  parameter int LINES = FRAME_LINES,
  parameter int W     = LINE_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_line,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_line,
  output logic [$clog2(LINES)-1:0] out_index,
  output logic                     done
);

  localparam int               IDX_W    = $clog2(LINES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] rd_prev;
  logic             done_q;
  logic             in_xfer;
  logic             out_xfer;
  logic [W-1:0]     mix_line;

  logic [W-1:0]     line_mem [LINES];
  logic [DIM-1:0]   par_mem  [LINES];

  assign in_xfer  = in_valid  & in_ready;
  assign out_xfer = out_valid & out_ready;

  // ---------------------------------------------------------------------------
  // FSM next-state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (wr_idx == LAST_IDX)) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready && (rd_idx == LAST_IDX)) begin
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counters and done pulse
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      wr_idx  <= '0;
      rd_idx  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= out_xfer && (rd_idx == LAST_IDX);
      // LINES is a power of two, so both counters wrap to 0 by overflow
      // exactly when a frame boundary is crossed.
      if (in_xfer) begin
        wr_idx <= wr_idx + IDX_ONE;
      end
      if (out_xfer) begin
        rd_idx <= rd_idx + IDX_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line and parity buffers
  // ---------------------------------------------------------------------------
  // NOTE: the buffers are deliberately left out of reset. Every entry is
  // written during LOAD before EMIT can read it, and out_line is masked
  // outside EMIT, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      line_mem[wr_idx] <= in_line;
      par_mem[wr_idx]  <= col_parity(in_line);
    end
  end

  // ---------------------------------------------------------------------------
  // Output mix
  // ---------------------------------------------------------------------------
  // Index arithmetic wraps at LINES, so slice 0 pairs with slice LINES-1.
  assign rd_prev = rd_idx - IDX_ONE;

  theta_mix u_theta_mix (
    .line     (line_mem[rd_idx]),
    .par_cur  (par_mem[rd_idx]),
    .par_prev (par_mem[rd_prev]),
    .mixed    (mix_line)
  );

  // Masking with out_valid keeps out_line at 0 in reset and LOAD, where the
  // buffer at rd_idx may hold an old or never-written line.
  assign out_line  = out_valid ? mix_line : '0;
  assign out_index = rd_idx;
  assign done      = done_q;

endmodule

// File: tb/tb_colparity_stage.sv
// -----------------------------------------------------------------------------
// tb_colparity_stage
//
// Self-checking bench for colparity_stage. Frames are loaded one line per
// cycle. Outputs are drained with steady or random out_ready. Each output
// is compared with a reference computed directly from the mixing formula
// on the whole frame held in an array. Inputs are driven and outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_colparity_stage;

  localparam int N = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] in_line;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_line;
  logic [5:0]  out_index;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [24:0] frame    [N];
  logic [24:0] exp_line [N];

  always #5 clk = ~clk;

  colparity_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_line   (in_line),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_line  (out_line),
    .out_index (out_index),
    .done      (done)
  );

  // Reference: out_z[5y+x] = line_z[5y+x] ^ C[x-1][z] ^ C[x+1][z-1], with
  // parities recomputed from the frame array for every query.
  function automatic logic [24:0] ref_mix(input int z);
    logic [4:0]  cz = '0;
    logic [4:0]  cp = '0;
    logic [24:0] r  = '0;
    int zp;
    zp = (z + N - 1) % N;
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        cz[x] = cz[x] ^ frame[z][5*y + x];
        cp[x] = cp[x] ^ frame[zp][5*y + x];
      end
    end
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        r[5*y + x] = frame[z][5*y + x] ^ cz[(x + 4) % 5] ^ cp[(x + 1) % 5];
      end
    end
    return r;
  endfunction

  task automatic fill_exp_from_model();
    for (int z = 0; z < N; z++) exp_line[z] = ref_mix(z);
  endtask

  task automatic fill_random_frame();
    for (int z = 0; z < N; z++) frame[z] = 25'($urandom());
  endtask

  // Called at a falling edge; returns at the falling edge after the last
  // accepted line.
  task automatic load_frame(input int count, input bit keep_valid);
    int n   = 0;
    int cyc = 0;
    bit acc;
    while (n < count && cyc < 4*N) begin
      in_valid = 1'b1;
      in_line  = frame[n];
      acc      = in_ready;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL load_in_ready n=%0d got %b exp 1", n, in_ready);
      end
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL load_out_valid n=%0d got %b exp 0", n, out_valid);
      end
      if (cyc == 1) begin
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL done_width got %b exp 0", done);
        end
      end
      @(posedge clk);
      if (acc) n++;
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (n < count) begin
      errors++;
      $display("FAIL load_timeout got %0d lines exp %0d", n, count);
    end
    if (!keep_valid) in_valid = 1'b0;
    if (count == N) begin
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL latency_out_valid got %b exp 1", out_valid);
      end
    end
  endtask

  // Called at a falling edge in EMIT; returns at the falling edge of the
  // done cycle.
  task automatic collect_frame(input bit rand_ready);
    int          k       = 0;
    int          cyc     = 0;
    bit          stalled = 1'b0;
    bit          rdy;
    logic [24:0] pl      = '0;
    logic [5:0]  pi      = '0;
    while (k < N && cyc < 20*N) begin
      rdy       = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      out_ready = rdy;
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL emit_out_valid k=%0d got %b exp 1", k, out_valid);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL emit_in_ready k=%0d got %b exp 0", k, in_ready);
      end
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL emit_done k=%0d got %b exp 0", k, done);
      end
      if (stalled) begin
        checks++;
        if (out_line !== pl || out_index !== pi) begin
          errors++;
          $display("FAIL stall_hold got %h/%0d exp %h/%0d", out_line, out_index, pl, pi);
        end
      end
      if (rdy) begin
        checks++;
        if (out_index !== 6'(k)) begin
          errors++;
          $display("FAIL out_index got %0d exp %0d", out_index, k);
        end
        checks++;
        if (out_line !== exp_line[k]) begin
          errors++;
          $display("FAIL out_line z=%0d got %h exp %h", k, out_line, exp_line[k]);
        end
        k++;
      end
      stalled = !rdy;
      pl      = out_line;
      pi      = out_index;
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++;
    if (k < N) begin
      errors++;
      $display("FAIL emit_timeout got %0d lines exp %0d", k, N);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse got %b exp 1", done);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL done_in_ready got %b exp 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_out_valid got %b exp 0", out_valid);
    end
  endtask

  task automatic check_done_low();
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_width got %b exp 0", done);
    end
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_index !== 6'd0 ||
        out_line !== 25'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s got rdy=%b vld=%b idx=%0d line=%h done=%b exp 1 0 0 0 0",
               tag, in_ready, out_valid, out_index, out_line, done);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_line   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset_state");
    rst = 1'b0;
    @(negedge clk);
    check_idle("after_reset");
  endtask

  task automatic test_zero_frame();
    for (int z = 0; z < N; z++) begin
      frame[z]    = '0;
      exp_line[z] = '0;
    end
    load_frame(N, 1'b0);
    collect_frame(1'b0);
    check_done_low();
  endtask

  task automatic test_single_bit();
    for (int z = 0; z < N; z++) begin
      frame[z]    = '0;
      exp_line[z] = '0;
    end
    frame[0]    = 25'h0000001;
    exp_line[0] = 25'h0210843;
    exp_line[1] = 25'h1084210;
    load_frame(N, 1'b0);
    collect_frame(1'b0);
    check_done_low();
  endtask

  task automatic test_wrap();
    for (int z = 0; z < N; z++) begin
      frame[z]    = '0;
      exp_line[z] = '0;
    end
    frame[N-1]    = 25'h0000001;
    exp_line[N-1] = 25'h0210843;
    exp_line[0]   = 25'h1084210;
    load_frame(N, 1'b0);
    collect_frame(1'b0);
    check_done_low();
  endtask

  task automatic test_random_backpressure();
    for (int f = 0; f < 2; f++) begin
      fill_random_frame();
      fill_exp_from_model();
      load_frame(N, 1'b0);
      collect_frame(1'b1);
      check_done_low();
    end
  endtask

  task automatic test_reset_mid_frame();
    fill_random_frame();
    load_frame(30, 1'b0);
    rst = 1'b1;
    #1;
    check_idle("async_reset");
    @(negedge clk);
    rst = 1'b0;
    fill_random_frame();
    fill_exp_from_model();
    load_frame(N, 1'b0);
    collect_frame(1'b1);
    check_done_low();
  endtask

  task automatic test_back_to_back();
    fill_random_frame();
    fill_exp_from_model();
    load_frame(N, 1'b1);
    // Second frame's first line waits on the bus through the whole emit.
    fill_random_frame();
    in_valid = 1'b1;
    in_line  = frame[0];
    collect_frame(1'b0);
    fill_exp_from_model();
    load_frame(N, 1'b0);
    collect_frame(1'b1);
    check_done_low();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_frame();
    test_single_bit();
    test_wrap();
    test_random_backpressure();
    test_reset_mid_frame();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
